// File: rtl/avsr_pkg.sv
// avalon_sample_reader shared types.
// State encoding and default parameter values.
package avsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int ADDR_W_D       = 18;
  localparam int DATA_W_D       = 32;
  localparam int LEN_W_D        = 16;
  localparam int READ_LATENCY_D = 1;
  localparam int FIFO_DEPTH_D   = 8;

endpackage

// File: rtl/avsr_fifo.sv
// Sample FIFO with a registered output stage.
// count includes the word held in the output register.
module avsr_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     ready,
  output logic                     valid,
  output logic [DATA_W-1:0]        data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       mcount;
  logic              pop;
  logic              load;
  logic              mem_rd;
  logic              bypass;
  logic              mem_wr;

  always_comb begin
    pop    = valid && ready;
    load   = !valid || pop;
    mem_rd = load && (mcount != '0);
    // empty storage: a fresh word goes straight to the output register
    bypass = load && (mcount == '0) && wr;
    mem_wr = wr && !bypass;
    count  = mcount + (AW+1)'(valid);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr   <= '0;
      rptr   <= '0;
      mcount <= '0;
      valid  <= 1'b0;
      data   <= '0;
    end else begin
      if (mem_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (mem_rd) begin
        rptr <= rptr + 1'b1;
      end
      mcount <= mcount + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
      if (load) begin
        valid <= mem_rd || bypass;
        if (mem_rd) begin
          data <= mem[rptr];
        end else if (bypass) begin
          data <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/avalon_sample_reader.sv
// Avalon-MM block read master feeding an Avalon-ST source.
// Reads are credit-limited so the output FIFO never overflows.
module avalon_sample_reader
  import avsr_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_D,
  parameter int DATA_W       = DATA_W_D,
  parameter int LEN_W        = LEN_W_D,
  parameter int READ_LATENCY = READ_LATENCY_D,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  state_t                  state_n;
  logic [ADDR_W-1:0]       addr;
  logic [LEN_W-1:0]        rem;
  logic [READ_LATENCY-1:0] flight;
  logic [CW-1:0]           nflight;
  logic [CW-1:0]           fcount;
  logic                    credit;
  logic                    issue;
  logic                    accept;
  logic                    kill;
  logic                    drained;
  logic                    done_n;

  always_comb begin
    nflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      nflight = nflight + CW'(flight[i]);
    end
  end

  // credit uses registered counts only; st_ready never reaches m_*
  always_comb begin
    credit  = ({1'b0, fcount} + {1'b0, nflight}) < (CW+1)'(FIFO_DEPTH);
    kill    = abort && (state != IDLE);
    issue   = (state == RUN) && credit && !abort;
    accept  = (state == IDLE) && start;
    drained = (nflight == '0) &&
              ((fcount == '0) ||
               ((fcount == CW'(1)) && st_valid && st_ready));
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (issue && (rem == LEN_W'(1))) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (drained) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      addr   <= '0;
      rem    <= '0;
      flight <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (accept) begin
        addr <= base_addr;
        rem  <= length;
      end else if (issue) begin
        addr <= addr + 1'b1;
        rem  <= rem - 1'b1;
      end
      if (kill) begin
        flight <= '0;
      end else begin
        flight <= READ_LATENCY'({flight, issue});
      end
    end
  end

  assign busy         = (state != IDLE);
  assign m_read       = issue;
  assign m_chipselect = issue;
  assign m_address    = addr;

  avsr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (kill),
    .wr    (flight[READ_LATENCY-1]),
    .wdata (m_readdata),
    .ready (st_ready),
    .valid (st_valid),
    .data  (st_data),
    .count (fcount)
  );

endmodule
